// File: rtl/pc_hazard_controller.sv
// Fetch-side sequencer for the 5-stage MIPS pipeline: selects the next PC, drives
// PC/IF-ID/ID-EX control for load-use stalls, redirects, memory freezes and boot hold.
module pc_hazard_controller #(
  parameter int ADDR_W      = 32,
  parameter int REG_W       = 5,
  parameter int BOOT_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic              ex_branch_taken,
  input  logic [ADDR_W-1:0] ex_branch_target,
  input  logic              id_jump,
  input  logic [ADDR_W-1:0] id_jump_target,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_uses_rt,
  input  logic              ex_mem_read,
  input  logic [REG_W-1:0]  ex_rt,
  input  logic              mem_busy,
  output logic [ADDR_W-1:0] pc_next,
  output logic              PC_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              pipe_hold,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    LU_STALL = 2'd2,
    MEM_WAIT = 2'd3
  } state_t;

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [3:0]       boot_cnt_q;
  logic [CNT_W-1:0] stall_count_q, flush_count_q;
  logic             stall_inc, flush_inc;
  logic             load_use;

  // $0 is hard-wired zero, so a load targeting it can never create a hazard.
  assign load_use = ex_mem_read && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    pc_next     = pc_plus4;
    PC_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_hold   = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    state_d     = state_q;

    if (state_q == BOOT) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      if (boot_cnt_q == BOOT_LAST) state_d = RUN;
    end else if (mem_busy) begin
      pipe_hold = 1'b1;
      state_d   = MEM_WAIT;
    end else if (ex_branch_taken) begin
      pc_next     = ex_branch_target;
      PC_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      flush_inc   = 1'b1;
      state_d     = RUN;
    end else if (id_jump) begin
      pc_next    = id_jump_target;
      PC_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b1;
      flush_inc  = 1'b1;
      state_d    = RUN;
    end else if (load_use && (state_q != LU_STALL)) begin
      // The bubble already went in last cycle; stalling again would lose an instruction.
      idex_bubble = 1'b1;
      stall_inc   = 1'b1;
      state_d     = LU_STALL;
    end else begin
      PC_write   = 1'b1;
      ifid_write = 1'b1;
      state_d    = RUN;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      boot_cnt_q    <= '0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == BOOT) boot_cnt_q <= boot_cnt_q + 4'd1;
      if (stall_inc && (stall_count_q != '1)) stall_count_q <= stall_count_q + CNT_W'(1);
      if (flush_inc && (flush_count_q != '1)) flush_count_q <= flush_count_q + CNT_W'(1);
    end
  end

  assign state       = state_q;
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_pc_hazard_controller.sv
// Self-checking bench for pc_hazard_controller: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a rule-level model.
module tb_pc_hazard_controller;

  localparam int ADDR_W = 32;
  localparam int REG_W  = 5;
  localparam int BOOT_N = 2;
  localparam int SAT_W  = 2;
  localparam longint BIG_MAX = 65535;
  localparam longint SAT_MAX = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] pc_plus4, ex_branch_target, id_jump_target;
  logic              ex_branch_taken, id_jump, id_uses_rt, ex_mem_read, mem_busy;
  logic [REG_W-1:0]  id_rs, id_rt, ex_rt;

  logic [ADDR_W-1:0] pc_next;
  logic              pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold;
  logic [1:0]        state;
  logic [15:0]       stall_count, flush_count;

  logic [ADDR_W-1:0] s_pc_next;
  logic              s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble, s_pipe_hold;
  logic [1:0]        s_state;
  logic [SAT_W-1:0]  s_stall_count, s_flush_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pc_hazard_controller #(.ADDR_W(ADDR_W), .REG_W(REG_W), .BOOT_CYCLES(BOOT_N), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .pc_plus4(pc_plus4),
    .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
    .id_jump(id_jump), .id_jump_target(id_jump_target),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .mem_busy(mem_busy),
    .pc_next(pc_next), .PC_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .pipe_hold(pipe_hold),
    .state(state), .stall_count(stall_count), .flush_count(flush_count)
  );

  // Narrow-counter copy sharing all inputs, used to observe saturation.
  pc_hazard_controller #(.ADDR_W(ADDR_W), .REG_W(REG_W), .BOOT_CYCLES(BOOT_N), .CNT_W(SAT_W)) dut_sat (
    .clk(clk), .rst(rst), .pc_plus4(pc_plus4),
    .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
    .id_jump(id_jump), .id_jump_target(id_jump_target),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .mem_busy(mem_busy),
    .pc_next(s_pc_next), .PC_write(s_pc_write), .ifid_write(s_ifid_write),
    .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble), .pipe_hold(s_pipe_hold),
    .state(s_state), .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  task automatic check(input string name, input longint actual, input longint expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit     model_valid = 1'b0;
  int     boot_left = 0;
  bit     in_lu = 1'b0, in_mw = 1'b0;
  longint stalls = 0, flushes = 0;

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  always @(negedge clk) begin
    logic [ADDR_W-1:0] e_pcn;
    bit  e_pcw, e_ifw, e_fl, e_bub, e_hold, match;
    int  e_state, outcome;  // 0 boot, 1 freeze, 2 redirect, 3 stall, 4 advance
    e_pcn = pc_plus4;
    e_pcw = 0; e_ifw = 0; e_fl = 0; e_bub = 0; e_hold = 0;
    match = ex_mem_read && (ex_rt != 0) &&
            ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    e_state = (boot_left > 0) ? 0 : in_mw ? 3 : in_lu ? 2 : 1;
    if (boot_left > 0) begin
      e_fl = 1; e_bub = 1; outcome = 0;
    end else if (mem_busy) begin
      e_hold = 1; outcome = 1;
    end else if (ex_branch_taken) begin
      e_pcn = ex_branch_target; e_pcw = 1; e_ifw = 1; e_fl = 1; e_bub = 1; outcome = 2;
    end else if (id_jump) begin
      e_pcn = id_jump_target; e_pcw = 1; e_ifw = 1; e_fl = 1; outcome = 2;
    end else if (match && !in_lu) begin
      e_bub = 1; outcome = 3;
    end else begin
      e_pcw = 1; e_ifw = 1; outcome = 4;
    end

    if (model_valid) begin
      check("pc_next", pc_next, e_pcn);
      check("PC_write", pc_write, e_pcw);
      check("ifid_write", ifid_write, e_ifw);
      check("ifid_flush", ifid_flush, e_fl);
      check("idex_bubble", idex_bubble, e_bub);
      check("pipe_hold", pipe_hold, e_hold);
      check("state", state, e_state);
      check("stall_count", stall_count, sat(stalls, BIG_MAX));
      check("flush_count", flush_count, sat(flushes, BIG_MAX));
      check("sat_state", s_state, e_state);
      check("sat_stall_count", s_stall_count, sat(stalls, SAT_MAX));
      check("sat_flush_count", s_flush_count, sat(flushes, SAT_MAX));
    end

    if (rst) begin
      model_valid = 1; boot_left = BOOT_N; in_lu = 0; in_mw = 0; stalls = 0; flushes = 0;
    end else if (model_valid) begin
      case (outcome)
        0: boot_left--;
        1: begin in_mw = 1; in_lu = 0; end
        2: begin in_mw = 0; in_lu = 0; flushes++; end
        3: begin in_mw = 0; in_lu = 1; stalls++; end
        default: begin in_mw = 0; in_lu = 0; end
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    ex_branch_taken = 0; ex_branch_target = '0;
    id_jump = 0; id_jump_target = '0;
    id_rs = '0; id_rt = '0; id_uses_rt = 0;
    ex_mem_read = 0; ex_rt = '0; mem_busy = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use_inputs();
    ex_mem_read = 1; ex_rt = 5'd5; id_rs = 5'd5;
  endtask

  initial begin
    idle();
    rst = 1;
    pc_plus4 = 32'h100;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #2;
    check("boot_c1_PC_write", pc_write, 0);
    check("boot_c1_state", state, 0);
    next_cycle(); #2;
    check("boot_c2_PC_write", pc_write, 0);
    check("boot_c2_state", state, 0);
    next_cycle(); #2;
    check("run_PC_write", pc_write, 1);
    check("run_state", state, 1);
    check("run_stall_count", stall_count, 0);
    check("run_flush_count", flush_count, 0);

    // Load-use held two cycles: one bubble, then advance.
    next_cycle(); load_use_inputs(); pc_plus4 = 32'h104; #2;
    check("lu1_PC_write", pc_write, 0);
    check("lu1_idex_bubble", idex_bubble, 1);
    next_cycle(); #2;
    check("lu2_state", state, 2);
    check("lu2_PC_write", pc_write, 1);
    check("lu2_pc_next", pc_next, 32'h104);
    check("lu2_stall_count", stall_count, 1);

    // Branch coinciding with a load-use match.
    next_cycle(); ex_branch_taken = 1; ex_branch_target = 32'h200; #2;
    check("br_pc_next", pc_next, 32'h200);
    check("br_ifid_flush", ifid_flush, 1);
    check("br_idex_bubble", idex_bubble, 1);

    // Jump.
    next_cycle(); idle(); id_jump = 1; id_jump_target = 32'h40; #2;
    check("br_flush_count", flush_count, 1);
    check("br_stall_count", stall_count, 1);
    check("j_pc_next", pc_next, 32'h40);
    check("j_ifid_flush", ifid_flush, 1);
    check("j_idex_bubble", idex_bubble, 0);
    check("j_PC_write", pc_write, 1);

    // Memory freeze with a pending branch.
    for (int i = 0; i < 3; i++) begin
      next_cycle(); idle(); mem_busy = 1; ex_branch_taken = 1; ex_branch_target = 32'h300; #2;
      check("mw_PC_write", pc_write, 0);
      check("mw_pipe_hold", pipe_hold, 1);
      if (i > 0) check("mw_state", state, 3);
    end
    next_cycle(); mem_busy = 0; #2;
    check("mw_exit_state", state, 3);
    check("mw_exit_pc_next", pc_next, 32'h300);
    check("mw_exit_PC_write", pc_write, 1);
    next_cycle(); idle(); #2;
    check("mw_flush_count", flush_count, 3);

    // Reset while frozen.
    next_cycle(); mem_busy = 1; #2;
    next_cycle(); rst = 1; #2;
    check("mr_state_before", state, 3);
    next_cycle(); rst = 0; idle(); #2;
    check("mr_state", state, 0);
    check("mr_stall_count", stall_count, 0);
    check("mr_flush_count", flush_count, 0);
    next_cycle();
    next_cycle();

    // Five load-use stalls saturate the narrow counter.
    repeat (5) begin
      next_cycle(); load_use_inputs(); #2;
      next_cycle(); idle(); #2;
    end
    next_cycle(); #2;
    check("sat_stall_3", s_stall_count, 3);
    check("wide_stall_5", stall_count, 5);

    // Randomized traffic; register specifiers drawn from a small set to force matches.
    repeat (3000) begin
      next_cycle();
      rst              = ($urandom_range(0, 199) == 0);
      mem_busy         = ($urandom_range(0, 99) < 15);
      ex_branch_taken  = ($urandom_range(0, 99) < 15);
      id_jump          = ($urandom_range(0, 99) < 10);
      ex_mem_read      = ($urandom_range(0, 99) < 50);
      id_uses_rt       = $urandom_range(0, 1);
      ex_rt            = 5'($urandom_range(0, 3));
      id_rs            = 5'($urandom_range(0, 3));
      id_rt            = 5'($urandom_range(0, 3));
      pc_plus4         = $urandom;
      ex_branch_target = $urandom;
      id_jump_target   = $urandom;
    end
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_hazard_controller.md
Name: pc_hazard_controller

Overview:
Fetch-side sequencer for the program counter register and the IF/ID and ID/EX pipeline registers of the 5-stage pipelined MIPS core.
- Each cycle it selects the next PC: PC+4, branch target or jump target.
- It drives the PC register's write enable, the IF/ID write/flush and the ID/EX bubble.
- It resolves load-use stalls, taken-branch/jump redirects, memory-busy freezes and a post-reset boot hold.
- It keeps saturating stall and flush counters for performance debug.

Parameters:
ADDR_W, 32, PC/target width
REG_W, 5, register-specifier width
BOOT_CYCLES, 2, cycles PC_write is held low after reset release (legal 1..15)
CNT_W, 16, width of performance counters

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
pc_plus4  in  ADDR_W  sequential next PC from fetch
ex_branch_taken  in  1  branch resolved taken in EX
ex_branch_target  in  ADDR_W  branch target from EX
id_jump  in  1  jump decoded in ID
id_jump_target  in  ADDR_W  jump target from ID
id_rs  in  REG_W  rs of instruction in ID
id_rt  in  REG_W  rt of instruction in ID
id_uses_rt  in  1  ID instruction reads rt
ex_mem_read  in  1  instruction in EX is a load
ex_rt  in  REG_W  load destination in EX
mem_busy  in  1  data/instruction memory not ready; whole pipe must freeze
pc_next  out  ADDR_W  value presented to PC register pc_in
PC_write  out  1  PC register write enable
ifid_write  out  1  IF/ID write enable
ifid_flush  out  1  clear IF/ID to NOP
idex_bubble  out  1  zero ID/EX control fields
pipe_hold  out  1  freeze ID/EX, EX/MEM, MEM/WB
state  out  2  0=BOOT 1=RUN 2=LU_STALL 3=MEM_WAIT
stall_count  out  CNT_W  load-use bubbles inserted, saturating
flush_count  out  CNT_W  branch+jump redirects, saturating

Behaviour:
- Reset: any edge with rst=1 sets state=BOOT, boot counter=0, stall_count=0, flush_count=0. This applies mid-operation too, overriding all other inputs.
- Outputs are combinational from state and current inputs (Mealy); only state and counters are registered.
- BOOT:
  - Outputs: PC_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, pipe_hold=0, pc_next=pc_plus4.
  - Boot counter increments each cycle. When it equals BOOT_CYCLES-1, next state is RUN.
  - BOOT therefore lasts exactly BOOT_CYCLES cycles after rst deasserts. All hazard inputs are ignored.
- RUN, MEM_WAIT and LU_STALL use one priority evaluation, first match wins:
  1. mem_busy=1: PC_write=0, ifid_write=0, ifid_flush=0, idex_bubble=0, pipe_hold=1. Next state MEM_WAIT.
  2. ex_branch_taken=1: pc_next=ex_branch_target, PC_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1. flush_count++. Next RUN.
  3. id_jump=1: pc_next=id_jump_target, PC_write=1, ifid_write=1, ifid_flush=1, idex_bubble=0. flush_count++. Next RUN.
  4. Load-use: ex_mem_read=1, ex_rt!=0, and (ex_rt==id_rs or (id_uses_rt and ex_rt==id_rt)). Outputs: PC_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0. stall_count++. Next LU_STALL.
  5. Otherwise: pc_next=pc_plus4, PC_write=1, ifid_write=1, all others 0. Next RUN.
- Outputs not listed in a rule are 0; pc_next=pc_plus4 unless stated.
- LU_STALL: rule 4 is suppressed, so at most one bubble is inserted per load. The state lasts one cycle unless rule 1 fires.
- MEM_WAIT: held while mem_busy=1. In the cycle mem_busy falls, rules 2-5 evaluate in that same cycle, with no dead cycle.
- Branch and mem_busy together: freeze wins. EX is held, so the branch redirects in the first non-busy cycle and is counted once.
- Branch and load-use together: branch wins and no stall is counted, since the ID instruction is flushed.
- Register $0 never triggers a stall.
- Counters stop at 2^CNT_W-1 and do not wrap.

Test Plan:
- Reset/boot: rst=1 for 2 cycles, then 0 with BOOT_CYCLES=2 → PC_write=0 for exactly 2 cycles after release, then 1; state 0→1; counters 0.
- Load-use: ex_mem_read=1, ex_rt=5, id_rs=5 held 2 cycles, pc_plus4=0x104 → cycle1 PC_write=0, idex_bubble=1, state→2; cycle2 PC_write=1, pc_next=0x104; stall_count=1.
- Branch: ex_branch_taken=1, target=0x200, plus load-use match same cycle → pc_next=0x200, ifid_flush=1, idex_bubble=1, flush_count=1, stall_count unchanged.
- Jump: id_jump=1, target=0x40 → pc_next=0x40, ifid_flush=1, idex_bubble=0, PC_write=1.
- Memory freeze: mem_busy=1 for 3 cycles with ex_branch_taken=1, target=0x300 → PC_write=0 and pipe_hold=1 for 3 cycles, state=3; 4th cycle pc_next=0x300, flush_count +1 only.
- Mid-operation reset and saturation: rst=1 while state=3 → state=0 next edge; with CNT_W=2, 5 load-use stalls → stall_count=3.
